// File: rtl/pipe_stage_reg.sv
// Pipeline-stage boundary register with a valid/ready handshake and a
// one-entry skid buffer, stage flush and synchronous preload.
// Optional stall counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg #(
  parameter int unsigned           WIDTH       = 109,
  parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}},
  parameter int unsigned           STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   flush,
  input  logic                   aload,
  input  logic [WIDTH-1:0]       adata,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_nxt;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_nxt;
  logic             in_fire;
  logic             out_fire;

  // State, storage and registered handshake flags
  always_ff @(posedge clk) begin
    if (areset) begin
      state     <= EMPTY;
      main_q    <= RESET_VALUE;
      skid_q    <= RESET_VALUE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      main_q    <= main_nxt;
      skid_q    <= skid_nxt;
      in_ready  <= (state_nxt != FULL);
      out_valid <= (state_nxt != EMPTY);
    end
  end

  // Next state and storage: flush > aload > handshake
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
    if (flush) begin
      // Held contents stay in place; only validity is dropped.
      state_nxt = EMPTY;
    end else if (aload) begin
      state_nxt = BUSY;
      main_nxt  = adata;
      skid_nxt  = {WIDTH{1'b0}};
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = BUSY;
            main_nxt  = in_data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            state_nxt = FULL;
            skid_nxt  = in_data;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt = BUSY;
            main_nxt  = skid_q;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  assign out_data = main_q;

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  // Saturating count of cycles where output is offered but not taken
  always_ff @(posedge clk) begin
    if (areset) begin
      stall_q <= {STALL_CNT_W{1'b0}};
    end else if (out_valid && !out_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = {STALL_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: stimulus pushes expected payloads,
// an independent monitor pops and compares on every downstream transfer.
module tb_pipe_stage_reg;

  localparam int unsigned W  = 109;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          areset;
  logic          flush;
  logic          aload;
  logic [W-1:0]  adata;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  pipe_stage_reg #(.WIDTH(W), .STALL_CNT_W(SW)) dut (
    .clk(clk), .areset(areset), .flush(flush), .aload(aload), .adata(adata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every downstream transfer must match the head of the scoreboard
  always @(negedge clk) begin
    if (!areset && !flush && !aload && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%0h, expected no transfer", out_data);
      end else begin
        check("scoreboard_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    areset = 1'b1; flush = 1'b0; aload = 1'b0; adata = '0;
    in_valid = 1'b1; in_data = W'(32'h1234); out_ready = 1'b0;

    // Reset with an offered payload that must not be captured
    step(); step();
    areset = 1'b0; in_valid = 1'b0;
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_in_ready",  W'(in_ready),  W'(1));
    check("reset_out_data",  out_data,      W'(0));
    step();
    check("reset_no_capture", W'(out_valid), W'(0));

    // Streaming 1..8 with the downstream always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      exp_q.push_back(W'(i));
      step();
      if (i == 1) begin
        check("latency_out_valid", W'(out_valid), W'(1));
        check("latency_out_data",  out_data,      W'(1));
      end
      check("stream_in_ready", W'(in_ready), W'(1));
    end
    in_valid = 1'b0;
    step(); step();
    check("stream_drained", W'(out_valid), W'(0));

    // Backpressure: two accepts while stalled fill the skid register
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = W'(32'hA); exp_q.push_back(W'(32'hA));
    step();
    in_data = W'(32'hB); exp_q.push_back(W'(32'hB));
    step();
    in_valid = 1'b0;
    check("bp_full_in_ready", W'(in_ready),  W'(0));
    check("bp_full_out_data", out_data,      W'(32'hA));
    check("bp_full_valid",    W'(out_valid), W'(1));
    step();
    check("bp_hold_out_data", out_data, W'(32'hA));
    out_ready = 1'b1;
    step();
    check("bp_ready_return", W'(in_ready), W'(1));
    check("bp_second_data",  out_data,     W'(32'hB));
    step();
    check("bp_drained", W'(out_valid), W'(0));
    out_ready = 1'b0;

    // Flush in FULL with a payload offered: nothing is delivered afterwards
    in_valid = 1'b1; in_data = W'(32'hA); step();
    in_data = W'(32'hB); step();
    check("flush_pre_full", W'(in_ready), W'(0));
    flush = 1'b1; in_data = W'(32'hC);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", W'(out_valid), W'(0));
    check("flush_in_ready",  W'(in_ready),  W'(1));
    out_ready = 1'b1;
    step(); step(); step();
    check("flush_nothing_left", W'(out_valid), W'(0));
    out_ready = 1'b0;

    // Preload wins over a same-cycle accept
    aload = 1'b1; adata = W'(32'h55); in_valid = 1'b1; in_data = W'(32'h66);
    step();
    aload = 1'b0; in_valid = 1'b0;
    check("aload_out_data",  out_data,      W'(32'h55));
    check("aload_out_valid", W'(out_valid), W'(1));
    check("aload_in_ready",  W'(in_ready),  W'(1));
    exp_q.push_back(W'(32'h55));
    out_ready = 1'b1;
    step(); step();
    check("aload_dropped_66", W'(out_valid), W'(0));
    out_ready = 1'b0;

    // Flush beats preload
    in_valid = 1'b1; in_data = W'(32'h77); step();
    in_valid = 1'b0;
    flush = 1'b1; aload = 1'b1; adata = W'(32'h99);
    step();
    flush = 1'b0; aload = 1'b0;
    check("prio_out_valid", W'(out_valid), W'(0));
    check("prio_in_ready",  W'(in_ready),  W'(1));

    // Long stall: counter saturates when enabled, stays 0 otherwise
    in_valid = 1'b1; in_data = W'(32'h42); exp_q.push_back(W'(32'h42));
    step();
    in_valid = 1'b0;
    repeat (20) step();
`ifdef PIPE_STAGE_STALL_CNT_EN
    check("stall_cnt_saturated", W'(stall_cnt), W'(15));
`else
    check("stall_cnt_tied_zero", W'(stall_cnt), W'(0));
`endif
    check("stall_hold_data", out_data, W'(32'h42));
    out_ready = 1'b1;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
    step();
    check("scoreboard_empty", W'(exp_q.size()), W'(0));
    check("final_out_valid",  W'(out_valid),    W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
